// File: rtl/led_pattern_sched.sv
// Command-driven LED pattern scheduler: a small command FIFO feeding a
// playback engine that steps SOLID/ROTATE/BLINK/OFF patterns on a divided tick.
module led_pattern_sched #(
    parameter int unsigned LED_W      = 2,
    parameter int unsigned TICK_DIV   = 10_000_000,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_mode,
    input  logic [LED_W-1:0] cmd_pattern,
    input  logic [7:0]       cmd_steps,
    output logic [LED_W-1:0] led,
    output logic             busy,
    output logic             done
);

    localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
    localparam int unsigned PTR_CW = PTR_W + 1;
    localparam int unsigned TICK_W = $clog2(TICK_DIV);

    typedef enum logic [1:0] {
        MODE_SOLID  = 2'd0,
        MODE_ROTATE = 2'd1,
        MODE_BLINK  = 2'd2,
        MODE_OFF    = 2'd3
    } mode_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    typedef struct packed {
        mode_e            mode;
        logic [LED_W-1:0] pattern;
        logic [7:0]       steps;
    } cmd_t;

    cmd_t               fifo_mem_q [FIFO_DEPTH];
    logic [PTR_CW-1:0]  wr_ptr_q, rd_ptr_q;
    logic               fifo_empty, fifo_full, push, pop;
    cmd_t               in_cmd, head;

    state_e             state_q, state_d;
    cmd_t               cur_q, cur_d;
    logic [TICK_W-1:0]  tick_q, tick_d;
    logic [7:0]         step_q, step_d;
    logic               phase_q, phase_d;
    logic [LED_W-1:0]   led_q, led_d;
    logic               done_q, done_d;
    logic               tick, finish, load;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                        (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
    assign cmd_ready  = !fifo_full;
    assign push       = cmd_valid && !fifo_full;
    assign head       = fifo_mem_q[rd_ptr_q[PTR_W-1:0]];

    assign in_cmd.mode    = mode_e'(cmd_mode);
    assign in_cmd.pattern = cmd_pattern;
    assign in_cmd.steps   = cmd_steps;

    assign busy = (state_q == ST_RUN) || !fifo_empty;
    assign led  = led_q;
    assign done = done_q;

    assign tick   = (state_q == ST_RUN) && (tick_q == TICK_W'(TICK_DIV - 1));
    // Counted commands end on their last step; forever commands yield to a queued one.
    assign finish = (cur_q.steps != 8'd0) ? (step_q == cur_q.steps - 8'd1) : !fifo_empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PTR_CW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push && !rst) fifo_mem_q[wr_ptr_q[PTR_W-1:0]] <= in_cmd;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cur_q   <= '0;
            tick_q  <= '0;
            step_q  <= '0;
            phase_q <= 1'b0;
            led_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cur_q   <= cur_d;
            tick_q  <= tick_d;
            step_q  <= step_d;
            phase_q <= phase_d;
            led_q   <= led_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cur_d   = cur_q;
        tick_d  = tick_q;
        step_d  = step_q;
        phase_d = phase_q;
        led_d   = led_q;
        done_d  = 1'b0;
        pop     = 1'b0;
        load    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                led_d = '0;
                if (!fifo_empty) load = 1'b1;
            end
            ST_RUN: begin
                tick_d = tick ? '0 : tick_q + TICK_W'(1);
                if (tick) begin
                    step_d = (step_q == 8'hFF) ? step_q : step_q + 8'd1;
                    if (finish) begin
                        done_d = 1'b1;
                        if (!fifo_empty) begin
                            load = 1'b1;
                        end else begin
                            state_d = ST_IDLE;
                            led_d   = '0;
                        end
                    end else begin
                        case (cur_q.mode)
                            MODE_SOLID:  led_d = led_q;
                            MODE_ROTATE: led_d = {led_q[LED_W-2:0], led_q[LED_W-1]};
                            MODE_BLINK: begin
                                phase_d = !phase_q;
                                led_d   = phase_q ? cur_q.pattern : '0;
                            end
                            MODE_OFF:    led_d = '0;
                            default:     led_d = '0;
                        endcase
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // A load overrides any mode update made on the same tick.
        if (load) begin
            pop     = 1'b1;
            cur_d   = head;
            tick_d  = '0;
            step_d  = '0;
            phase_d = 1'b0;
            led_d   = (head.mode == MODE_OFF) ? '0 : head.pattern;
            state_d = ST_RUN;
        end
    end

endmodule

// File: doc/led_pattern_sched.md
# led_pattern_sched

Command-driven LED pattern scheduler for the board status LEDs. Requesters push pattern commands (mode, seed pattern, step count) through a valid/ready port into a 4-entry FIFO. The block plays the commands back one after another, advancing the pattern on a programmable tick. It replaces the free-running fixed-rotation flasher and sits between control logic and the LED pins.

## Interface
- `LED_W`, default 2: LED vector width, must be ≥ 2.
- `TICK_DIV`, default 10_000_000: clock cycles per pattern step, must be ≥ 2.
- `FIFO_DEPTH`, default 4: command queue depth, must be a power of 2.
- `clk` in, 1: system clock. All logic is on the rising edge.
- `rst` in, 1: one clock; reset is synchronous and active-high.
- `cmd_valid` in, 1: command present.
- `cmd_ready` out, 1: FIFO not full (`!full`). A command is accepted when `cmd_valid && cmd_ready` at a rising edge.
- `cmd_mode` in, 2: 0 SOLID, 1 ROTATE, 2 BLINK, 3 OFF.
- `cmd_pattern` in, LED_W: seed pattern.
- `cmd_steps` in, 8: ticks to play. 0 means play until preempted.
- `led` out, LED_W: registered LED drive.
- `busy` out, 1: `state==RUN || !fifo_empty`.
- `done` out, 1: one-cycle pulse when a counted command completes or a forever command is preempted.

## Operation
- **Reset values:** FIFO empty, state IDLE, `led`=0, `done`=0, tick_cnt=0, step_cnt=0, blink phase=0. While `rst` is high, `cmd_ready` reads 1 and pushes are ignored.
- **FIFO:**
  - Stores {mode, pattern, steps}.
  - Push and pop in the same cycle are legal; the count is unchanged.
  - No push occurs when full, because ready is low.
  - Pointers wrap modulo FIFO_DEPTH.
  - An extra count bit distinguishes full from empty.
- **IDLE:**
  - `led` is held at 0.
  - When the FIFO is non-empty, the block pops the head, loads the command registers, and sets tick_cnt=0, step_cnt=0, phase=0.
  - `led` takes the start value for the mode: SOLID, ROTATE and BLINK use `pattern`; OFF uses 0.
  - State moves to RUN.
- **RUN:** tick_cnt counts 0..TICK_DIV-1. A *tick* is the cycle with tick_cnt==TICK_DIV-1; tick_cnt wraps to 0 on that cycle.
- **Effect of a tick on `led`:**
  - SOLID: hold.
  - ROTATE: rotate left, `{led[LED_W-2:0], led[LED_W-1]}`.
  - BLINK: phase toggles; `led` is 0 when the new phase is 1, otherwise `pattern`.
  - OFF: 0.
- **Effect of a tick on step_cnt:** step_cnt increments, saturating at 255.
- **Completion (counted command):** when steps≠0 and a tick occurs with step_cnt==steps-1:
  - `done` pulses.
  - If the FIFO is non-empty, the next command is popped and loaded on the same edge. It has the start value, tick_cnt=0, and there is no IDLE gap.
  - Otherwise the block returns to IDLE and `led` is 0.
- **Preemption (forever command):** with steps==0, on any tick where the FIFO is non-empty:
  - `done` pulses.
  - The next command is loaded as above.
  - With an empty FIFO the command runs indefinitely. step_cnt is ignored.
- **Priority on a tick:** completion or preemption overrides the mode update. The new command's start value is written, not the rotated value.
- **Mid-run reset:** `rst` aborts everything in one edge to reset values, and queued commands are discarded.

## Timing
- A command is accepted at edge N into an empty FIFO while IDLE. The pop and `led` update happen at edge N+1. `busy` is high from after edge N.
- The first mode update occurs exactly TICK_DIV cycles after the load edge. Subsequent updates follow every TICK_DIV cycles.
- A counted command occupies exactly steps×TICK_DIV cycles from its load edge to the completion edge.
- `done` is high for the single cycle following the completion edge.
- `cmd_ready` falls the cycle after the FIFO_DEPTH-th unpopped push. It rises the cycle after a pop from full.
- All outputs except `cmd_ready` and `busy` are registered. Those two are decoded from registers only and have no combinational path from inputs.

## Test plan
All scenarios use TICK_DIV=4 and LED_W=2.

1. **Reset.** Hold `rst` 3 cycles, then release. Required: `led`=00, `done`=0, `busy`=0, `cmd_ready`=1. With `cmd_valid` pulsed during reset, nothing is queued afterwards.
2. **ROTATE.** Push ROTATE, pattern 10, steps 3. Required: `led`=10 after load, then 01 at +4, 10 at +8. `done` pulses at +12 and `led`=00 (IDLE), `busy` falls.
3. **BLINK then SOLID back-to-back.** Push BLINK 11 steps 2, then SOLID 01 steps 1. Required: `led` 11, 00, then 01 at +8 with no 00 gap cycle. Two `done` pulses at +8 and +12.
4. **Preemption.** Push ROTATE 01 steps 0 and let it run 10 cycles. Then push OFF steps 1. Required: the switch to 00 occurs only at the next tick edge, `done` pulses at that edge, and a second `done` pulses 4 cycles later.
5. **FIFO full.** While a forever command runs, push 5 commands with valid held. Required: 4 are accepted and `cmd_ready`=0 blocks the 5th. After the next tick pop, `cmd_ready`=1 and the 5th is accepted. Playback order equals push order.
6. **Reset mid-run.** Assert `rst` at tick_cnt=2 of a ROTATE with 2 commands queued. Required: all reset values next cycle, and the queue is empty (`busy`=0).
